hazard_detect: RTL

Issue-side hazard unit for the 5-stage MIPS pipeline, sitting in ID across from the EX-stage forwarding unit. It detects dependencies that forwarding cannot cover: load-use hazards and branches resolved in ID that need an operand not yet available. It stalls PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken branches and jumps. A small FSM holds multi-cycle stalls, and a counter records stall cycles for performance monitoring.

---
 rtl/hazard_detect.sv | 57 +++++
 1 files changed

// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage load-use/branch hazard stall, bubble and flush control with a saturating stall-cycle counter
module hazard_detect #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IfIdRs,
   input  logic [4:0]       IfIdRt,
   input  logic             IfIdUsesRt,
   input  logic             IfIdBranch,
   input  logic             IfIdJump,
   input  logic             BranchTaken,
   input  logic             IdExMemRead,
   input  logic             IdExRegWrite,
   input  logic [4:0]       IdExRd,
   input  logic             ExMemMemRead,
   input  logic [4:0]       ExMemRd,
   output logic             PcWrite,
   output logic             IfIdWrite,
   output logic             IdExBubble,
   output logic             IfIdFlush,
   output logic [CNT_W-1:0] StallCount
);
   typedef enum logic {RUN, HOLD} stateE;
   stateE state;
   logic [1:0] remaining, need;
   logic matchEx, matchMem, hazA, hazB, hazC, stall;
   always_comb begin
      matchEx = IdExRd != 5'd0 && (IdExRd == IfIdRs || (IfIdUsesRt && IdExRd == IfIdRt));
      matchMem = ExMemRd != 5'd0 && (ExMemRd == IfIdRs || (IfIdUsesRt && ExMemRd == IfIdRt));
      hazA = IdExMemRead && matchEx;
      hazB = IfIdBranch && IdExRegWrite && !IdExMemRead && matchEx;
      hazC = IfIdBranch && ExMemMemRead && matchMem;
      need = hazA ? (IfIdBranch ? 2'd2 : 2'd1) : (hazB || hazC) ? 2'd1 : 2'd0;
      stall = rst_n && (state == HOLD || need != 2'd0);
      PcWrite = !stall;
      IfIdWrite = !stall;
      IdExBubble = stall;
      IfIdFlush = rst_n && !stall && (IfIdJump || (IfIdBranch && BranchTaken));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         remaining <= 2'd0;
         StallCount <= '0;
      end else begin
         if (stall && StallCount != '1) StallCount <= StallCount + 1'b1;
         if (state == HOLD) begin
            remaining <= remaining - 2'd1;
            if (remaining == 2'd1) state <= RUN;
         end else if (need >= 2'd2) begin
            state <= HOLD;
            remaining <= need - 2'd1;
         end
      end
   end
endmodule
